// File: rtl/pc_tx_serialiser.sv
`default_nettype none
// ============================================================================
// Module   : pc_tx_serialiser
// Purpose  : Serialises a 32-bit word to a PC over UART as four bytes,
//            MSB byte first. Each byte is framed as start(0), 8 data bits
//            LSB first, optional even parity, stop(1). Consecutive bytes are
//            sent with no idle gap between them.
// Options  : define PC_TX_PARITY_EN to add an even-parity bit (8E1 frames);
//            when it is undefined, 8N1 frames are sent.
// Revision : 1.0 - initial release
// ============================================================================
module pc_tx_serialiser #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_data_word,
  input  logic        i_send_cmd,
  output logic        o_busy,
  output logic        o_uart_tx,
  output logic        o_word_done
);

  // Baud counter counts down from CLKS_PER_BIT-1 to 0, so this width is enough.
  localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_RELOAD = c_BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef PC_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t              r_state;
  logic [31:0]         r_word;
  logic [c_BAUD_W-1:0] r_baud;
  logic [2:0]          r_bit_idx;
  logic [1:0]          r_byte_idx;
  logic                r_tx;
  logic                r_done;

  logic [7:0]          w_cur_byte;
  logic [2:0]          w_next_bit_idx;
  logic                w_bit_end;
`ifdef PC_TX_PARITY_EN
  logic                w_parity;
`endif

  // Select the byte currently on the wire; byte 0 is the most significant.
  always_comb begin
    w_cur_byte = r_word[31:24];
    case (r_byte_idx)
      2'd0:    w_cur_byte = r_word[31:24];
      2'd1:    w_cur_byte = r_word[23:16];
      2'd2:    w_cur_byte = r_word[15:8];
      default: w_cur_byte = r_word[7:0];
    endcase
  end

  assign w_next_bit_idx = r_bit_idx + 3'd1;
  assign w_bit_end      = (r_baud == '0);
`ifdef PC_TX_PARITY_EN
  assign w_parity       = ^w_cur_byte;
`endif

  // Busy is combinational so a requester sees it in the cycle it issues a command.
  assign o_busy      = (r_state != S_IDLE) | i_send_cmd | i_reset;
  assign o_uart_tx   = r_tx;
  assign o_word_done = r_done;

  // Frame sequencer: every bit is held for CLKS_PER_BIT cycles, line and done are registered.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_word     <= '0;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (i_send_cmd) begin
            r_word     <= i_data_word;
            r_byte_idx <= 2'd0;
            r_bit_idx  <= 3'd0;
            r_baud     <= c_BAUD_RELOAD;
            r_tx       <= 1'b0;
            r_state    <= S_START;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_baud    <= c_BAUD_RELOAD;
            r_bit_idx <= 3'd0;
            r_tx      <= w_cur_byte[0];
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud - c_BAUD_W'(1);
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= c_BAUD_RELOAD;
            if (r_bit_idx == 3'd7) begin
`ifdef PC_TX_PARITY_EN
              r_tx    <= w_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_idx <= w_next_bit_idx;
              r_tx      <= w_cur_byte[w_next_bit_idx];
            end
          end else begin
            r_baud <= r_baud - c_BAUD_W'(1);
          end
        end

`ifdef PC_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_baud  <= c_BAUD_RELOAD;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud - c_BAUD_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (w_bit_end) begin
            if (r_byte_idx == 2'd3) begin
              // Last stop bit of the word: report completion and go idle together.
              r_done  <= 1'b1;
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              // Next byte's start bit follows the stop bit with no gap.
              r_byte_idx <= r_byte_idx + 2'd1;
              r_baud     <= c_BAUD_RELOAD;
              r_tx       <= 1'b0;
              r_state    <= S_START;
            end
          end else begin
            r_baud <= r_baud - c_BAUD_W'(1);
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_tx_serialiser.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_tx_serialiser
// Purpose  : Self-checking bench for pc_tx_serialiser (CLKS_PER_BIT = 4).
//            A queue model predicts the line level cycle by cycle; literal
//            checks pin decoded bytes, latencies and corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_tx_serialiser;

  localparam int CPB = 4;
`ifdef PC_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int WORD_CYC = FRAME * 4 * CPB;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_data_word = 32'h0;
  logic        i_send_cmd = 1'b0;
  logic        o_busy;
  logic        o_uart_tx;
  logic        o_word_done;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit checking = 1'b0;

  bit   q[$];
  bit   m_done = 1'b0;
  logic tx_log [0:8191];
  int   done_cnt = 0;
  int   last_done = -1;
  int   busy_run = 0;
  int   last_busy_run = 0;
  int   hi_run = 0;
  int   last_hi_run = 0;

  pc_tx_serialiser #(.CLKS_PER_BIT(CPB)) dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_data_word (i_data_word),
    .i_send_cmd  (i_send_cmd),
    .o_busy      (o_busy),
    .o_uart_tx   (o_uart_tx),
    .o_word_done (o_word_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Expected line levels of one whole word, one entry per clock cycle.
  function automatic void push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) begin
      logic [7:0] by;
      by = w[b*8 +: 8];
      for (int k = 0; k < CPB; k++) q.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < CPB; k++) q.push_back(by[i]);
`ifdef PC_TX_PARITY_EN
      for (int k = 0; k < CPB; k++) q.push_back(^by);
`endif
      for (int k = 0; k < CPB; k++) q.push_back(1'b1);
    end
  endfunction

  // Per-cycle compare against the model, then advance the model one cycle.
  always @(negedge clk) begin
    if (checking) begin
      check("tx",   32'(o_uart_tx),   32'((q.size() != 0) ? q[0] : 1'b1));
      check("busy", 32'(o_busy),      32'((q.size() != 0) || i_send_cmd || i_reset));
      check("done", 32'(o_word_done), 32'(m_done));
    end
    if (cyc < 8192) tx_log[cyc] = o_uart_tx;
    if (o_word_done === 1'b1) begin
      done_cnt++;
      last_done = cyc;
    end
    if (o_busy === 1'b1) busy_run++;
    else begin
      if (busy_run != 0) last_busy_run = busy_run;
      busy_run = 0;
    end
    if (o_uart_tx === 1'b1) hi_run++;
    else begin
      if (hi_run != 0) last_hi_run = hi_run;
      hi_run = 0;
    end
    if (i_reset) begin
      q.delete();
      m_done = 1'b0;
    end else begin
      m_done = (q.size() == 1);
      if (q.size() != 0) void'(q.pop_front());
      else if (i_send_cmd) push_word(i_data_word);
    end
  end

  function automatic logic [7:0] dec_byte(input int s, input int j);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = tx_log[s + j*FRAME*CPB + (1+i)*CPB + CPB/2];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_word(input logic [31:0] w, output int s);
    tick();
    i_data_word = w;
    i_send_cmd  = 1'b1;
    s = cyc + 1;
    tick();
    i_send_cmd  = 1'b0;
    i_data_word = 32'h5A5A_5A5A;
  endtask

  task automatic wait_done(input int limit);
    int c0;
    int n;
    c0 = done_cnt;
    n = 0;
    while (done_cnt == c0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_timeout", 32'(done_cnt != c0), 32'd1);
  endtask

  task automatic check_word(input string name, input int s, input logic [31:0] w);
    for (int j = 0; j < 4; j++) check(name, 32'(dec_byte(s, j)), 32'(w[(3-j)*8 +: 8]));
    check({name, "_latency"}, last_done - s, WORD_CYC);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s, s2, n, c0, target;
    // Reset held for three edges.
    @(posedge clk);
    #1;
    checking = 1'b1;
    @(negedge clk);
    #1;
    check("reset_tx",   32'(o_uart_tx), 32'd1);
    check("reset_busy", 32'(o_busy),    32'd1);
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    @(negedge clk);
    #1;
    check("post_reset_busy", 32'(o_busy),      32'd0);
    check("post_reset_done", 32'(o_word_done), 32'd0);
    check("post_reset_tx",   32'(o_uart_tx),   32'd1);

    // Single word.
    start_word(32'hA5C3_0F81, s);
    wait_done(400);
    check_word("word1", s, 32'hA5C3_0F81);
    check("word1_lit_byte0", 32'(dec_byte(s, 0)), 32'h0000_00A5);
`ifndef PC_TX_PARITY_EN
    check("word1_lit_latency", last_done - s, 160);
`endif

    // Commands 1, 2 and 50 cycles after acceptance are ignored.
    start_word(32'hA5C3_0F81, s);
    i_send_cmd = 1'b1;
    i_data_word = 32'hDEAD_BEEF;
    tick();
    i_data_word = 32'hCAFE_F00D;
    tick();
    i_send_cmd = 1'b0;
    repeat (47) tick();
    i_send_cmd = 1'b1;
    i_data_word = 32'h1111_2222;
    tick();
    i_send_cmd = 1'b0;
    wait_done(400);
    check_word("ignored_cmd", s, 32'hA5C3_0F81);

    // Back-to-back words, second command in the done cycle.
    start_word(32'h0000_0000, s);
    n = 0;
    while (o_word_done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("b2b_done_seen", 32'(o_word_done), 32'd1);
    i_data_word = 32'hFFFF_FFFF;
    i_send_cmd = 1'b1;
    s2 = cyc + 1;
    check("b2b_word1_latency", cyc - s, WORD_CYC);
    tick();
    i_send_cmd = 1'b0;
    @(negedge clk);
    #1;
    // High run between words: last stop bit plus the one done/accept cycle.
    check("b2b_gap", last_hi_run, CPB + 1);
    wait_done(400);
    check_word("b2b_word2", s2, 32'hFFFF_FFFF);
    for (int j = 0; j < 4; j++) check("b2b_word1", 32'(dec_byte(s, j)), 32'h0000_0000);
    // 2*WORD_CYC frame cycles plus both acceptance cycles.
    check("b2b_busy_run", last_busy_run, 2*WORD_CYC + 2);

    // Reset during bit 3 of byte index 2 aborts the word.
    start_word(32'h0000_0000, s);
    target = s + 2*FRAME*CPB + 4*CPB;
    n = 0;
    while (cyc < target && n < 400) begin
      tick();
      n++;
    end
    check("abort_reached", cyc, target);
    check("abort_pre_tx", 32'(o_uart_tx), 32'd0);
    c0 = done_cnt;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("abort_tx_high", 32'(o_uart_tx), 32'd1);
    repeat (200) tick();
    check("abort_no_done", done_cnt, c0);
    start_word(32'h1234_5678, s);
    wait_done(400);
    check_word("after_abort", s, 32'h1234_5678);

`ifdef PC_TX_PARITY_EN
    // Even parity of 01,03,07,00 is 1,0,1,0.
    start_word(32'h0103_0700, s);
    wait_done(400);
    check_word("parity_word", s, 32'h0103_0700);
    check("parity_b0", 32'(tx_log[s + 0*FRAME*CPB + 9*CPB + CPB/2]), 32'd1);
    check("parity_b1", 32'(tx_log[s + 1*FRAME*CPB + 9*CPB + CPB/2]), 32'd0);
    check("parity_b2", 32'(tx_log[s + 2*FRAME*CPB + 9*CPB + CPB/2]), 32'd1);
    check("parity_b3", 32'(tx_log[s + 3*FRAME*CPB + 9*CPB + CPB/2]), 32'd0);
    check("parity_lit_latency", last_done - s, 176);
`endif

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
